// File: rtl/ld_exec_unit.sv
// ld_exec_unit -- single-outstanding load execution engine.
//
// Takes one load at a time from the load buffer, issues a word-aligned
// read to the data cache, extracts and sign/zero-extends the requested
// byte/half/word, then broadcasts the result with its ROB tag.
//
// Optional build macro: LD_EXEC_TIMEOUT_EN
//   defined   -> WAIT/DRAIN watchdog of TIMEOUT_CYCLES cycles; expiry in WAIT
//                reissues the same request, expiry in DRAIN returns to IDLE.
//   undefined -> WAIT/DRAIN wait indefinitely for dc_resp_valid.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. A producer holding valid keeps its payload stable
// until that edge and never withdraws valid on its own (flush and reset
// excepted). dc_resp_valid is a one-cycle strobe without backpressure.
//
// Ports:
//   clk, rst_aL              clock, asynchronous active-low reset
//   ld_valid/ld_ready        load-buffer dequeue handshake
//   ld_addr/ld_width/ld_rob_id  load payload (funct3 width code)
//   dc_req_valid/dc_req_ready/dc_req_addr  cache read request
//   dc_resp_valid/dc_resp_data             cache read response
//   bcast_valid/bcast_ready/bcast_rob_id/bcast_data  result broadcast
//   flush                    squash the in-flight load
//   busy                     high whenever not IDLE
//   dbg_state                current FSM state encoding (debug/checkers)
module ld_exec_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ROB_ID_WIDTH   = 6,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst_aL,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [ADDR_WIDTH-1:0]   ld_addr,
    input  logic [2:0]              ld_width,
    input  logic [ROB_ID_WIDTH-1:0] ld_rob_id,
    output logic                    dc_req_valid,
    input  logic                    dc_req_ready,
    output logic [ADDR_WIDTH-1:0]   dc_req_addr,
    input  logic                    dc_resp_valid,
    input  logic [DATA_WIDTH-1:0]   dc_resp_data,
    output logic                    bcast_valid,
    input  logic                    bcast_ready,
    output logic [ROB_ID_WIDTH-1:0] bcast_rob_id,
    output logic [DATA_WIDTH-1:0]   bcast_data,
    input  logic                    flush,
    output logic                    busy,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_BCAST = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [2:0]              r_width;
    logic [ROB_ID_WIDTH-1:0] r_rob_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    w_accept;
    logic                    w_take_resp;
    logic                    w_tmo_expire;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_ext;

    // Watchdog: counts cycles spent in WAIT or DRAIN, cleared whenever the
    // state changes so each WAIT/DRAIN visit gets a full window.
`ifdef LD_EXEC_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_tmo_cnt <= '0;
        end else if (w_next != r_state) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_WAIT || r_state == S_DRAIN) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // The last waiting cycle is the one where the count would reach the limit.
    assign w_tmo_expire = (r_state == S_WAIT || r_state == S_DRAIN) &&
                          (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_tmo_expire = 1'b0;
`endif

    // Lane extraction from the aligned word using the latched byte offset.
    always_comb begin
        w_byte = dc_resp_data[{r_addr[1:0], 3'b000} +: 8];
        w_half = dc_resp_data[{r_addr[1], 4'b0000} +: 16];
        case (r_width)
            3'b000:  w_ext = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            3'b100:  w_ext = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            3'b101:  w_ext = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_ext = dc_resp_data;  // lw and reserved codes
        endcase
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and outputs; flush outranks every other event.
    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_take_resp  = 1'b0;
        ld_ready     = 1'b0;
        dc_req_valid = 1'b0;
        bcast_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                ld_ready = ~flush;
                if (!flush && ld_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_REQ;
                end
            end
            S_REQ: begin
                dc_req_valid = 1'b1;
                if (flush) begin
                    w_next = S_IDLE;
                end else if (dc_req_ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    w_next = S_DRAIN;
                end else if (dc_resp_valid) begin
                    w_take_resp = 1'b1;
                    w_next      = S_BCAST;
                end else if (w_tmo_expire) begin
                    w_next = S_REQ;
                end
            end
            S_BCAST: begin
                bcast_valid = 1'b1;
                if (flush || bcast_ready) begin
                    w_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                // The response of the squashed load is swallowed here.
                if (dc_resp_valid || w_tmo_expire) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_addr   <= '0;
            r_width  <= '0;
            r_rob_id <= '0;
            r_data   <= '0;
        end else begin
            if (w_accept) begin
                r_addr   <= ld_addr;
                r_width  <= ld_width;
                r_rob_id <= ld_rob_id;
            end
            if (w_take_resp) begin
                r_data <= w_ext;
            end
        end
    end

    assign dc_req_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign bcast_rob_id = r_rob_id;
    assign bcast_data   = r_data;
    assign busy         = (r_state != S_IDLE);
    assign dbg_state    = r_state;

endmodule
